axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR/R) between the instruction-cache and data-cache line-refill ports.
- Accepts one line-fill request at a time and issues one INCR burst.
- Steers R beats back only to the requester that owns the burst.
- Sits between the two directCache bus-side command ports and the top-level m_axi read signals.

Parameters:
- ID_WIDTH, 13: AXI ID width.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 64: AXI data width.
- BURST_LEN, 8: beats per line fill. Line size is BURST_LEN*DATA_WIDTH/8 bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- ic_req_valid  in  1  I-cache refill request.
- ic_req_addr  in  ADDR_WIDTH  I-cache miss address.
- ic_req_ready  out  1  I-cache request accepted.
- ic_rdata  out  DATA_WIDTH  refill beat data.
- ic_rvalid  out  1  refill beat valid.
- ic_rlast  out  1  last beat.
- dc_req_valid, dc_req_addr, dc_req_ready, dc_rdata, dc_rvalid, dc_rlast: same as the ic_* ports, for the D-cache.
- m_axi_arid  out  ID_WIDTH.
- m_axi_araddr  out  ADDR_WIDTH.
- m_axi_arlen  out  8.
- m_axi_arsize  out  3.
- m_axi_arburst  out  2.
- m_axi_arlock  out  1.
- m_axi_arcache  out  4.
- m_axi_arprot  out  3.
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rid  in  ID_WIDTH.
- m_axi_rdata  in  DATA_WIDTH.
- m_axi_rresp  in  2.
- m_axi_rlast  in  1.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.
- err  out  1  sticky protocol/response error.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-low.
- Reset state while reset=0:
  - FSM in IDLE; arvalid=0, rready=0.
  - All *_req_ready, *_rvalid and *_rlast are 0; err=0.
  - last_grant=DC, so the I-cache wins the first tie.
- Reset mid-burst: state is abandoned immediately; no beats are forwarded afterward. The bus is reset concurrently by system convention.
- FSM states: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If exactly one *_req_valid is high, grant it.
  - If both are high, grant the requester opposite to last_grant (round-robin).
  - Grant cycle: assert that requester's *_req_ready combinationally, for that cycle only.
  - On the grant edge: latch the address, owner and ID, update last_grant, and go to ADDR.
  - Requesters hold valid and addr stable until ready.
- ADDR:
  - arvalid=1.
  - araddr = latched address with the low log2(BURST_LEN*DATA_WIDTH/8) bits cleared.
  - arlen = BURST_LEN-1; arsize = log2(DATA_WIDTH/8); arburst = 2'b01 (INCR); arlock = 0; arcache = 4'b0011; arprot = 3'b000.
  - arid = owner bit in bit 0 (0 = IC, 1 = DC), upper bits zero.
  - All AR outputs stay stable until arready. On arvalid&arready, go to DATA and clear the beat counter.
- Latency: request accepted at cycle T means arvalid at T+1.
- DATA:
  - rready=1. Caches cannot back-pressure.
  - Each rvalid&rready beat is registered and presented to the owner one cycle later: *_rdata, a one-cycle *_rvalid pulse, and *_rlast = m_axi_rlast.
  - The non-owner's rvalid stays 0.
  - The beat counter is width ceil(log2(BURST_LEN))+1 and saturates at BURST_LEN.
  - On a beat carrying rlast, go to IDLE. The next grant can occur in the cycle after the owner sees rlast.
- Error conditions: err is set on any of the following, and stays set until reset:
  - rresp != 0 on a beat;
  - rid != latched arid;
  - rlast arrives with count != BURST_LEN-1;
  - a beat arrives after the counter reaches BURST_LEN-1 without rlast.
- Error handling: erroneous beats are still forwarded to the owner. The FSM exits DATA only on rlast.
- Outside DATA: rready=0, and rvalid from the bus is ignored.
- Simultaneous events: a request arriving during ADDR or DATA waits; its ready stays 0. The last DATA beat and a new request in the same cycle are handled per the DATA rule (no grant until IDLE).

Optional Feature:
- Macro: AXI_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority, where dc_req_valid always wins a tie. last_grant is still maintained but ignored.
- Undefined: round-robin as above.

Decomposition:
- Shared package axi_arb_pkg:
  - arb_state_e enum {IDLE, ADDR, DATA};
  - owner_e {OWN_IC=0, OWN_DC=1};
  - constants AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00.
- One natural sub-module: rr_arbiter2. It is a 2-way round-robin grant with a last_grant flop, and an input selecting fixed priority under the macro.

Test Plan:
- IC only: ic_req_addr=0x1000_0024 -> ic_req_ready at T; araddr=0x1000_0000, arlen=7, arid=0 at T+1; 8 beats 0..7 -> ic_rvalid 8 pulses with ic_rlast on the 8th; dc_rvalid stays 0.
- Tie: both requests valid at T after reset -> IC granted first, DC granted in the cycle after the IC rlast; arid=1; a third back-to-back tie goes to IC.
- arready delayed 5 cycles -> arvalid and araddr stable all 5 cycles; no rready before the handshake.
- Error: rresp=2'b10 on beat 3 -> err=1 and stays set; all 8 beats forwarded. Early rlast on beat 5 -> err=1; FSM returns to IDLE.
- reset driven low asynchronously on beat 4 -> arvalid, rready and all outputs at 0 before the next edge; after release, a new IC request is accepted normally.
- With AXI_ARB_DCACHE_PRIO_EN: two consecutive ties -> DC granted both times.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM/owner encodings and AXI constants for axi_read_arbiter.
package axi_arb_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way IC/DC grant, round-robin on ties unless fixed_prio forces DC.
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic fixed_prio,
    input  logic req_ic,
    input  logic req_dc,
    output logic gnt_ic,
    output logic gnt_dc
);
    owner_e last_q, last_d;
    always_comb begin
        gnt_dc = en & req_dc & (~req_ic | fixed_prio | (last_q == OWN_IC));
        gnt_ic = en & req_ic & ~gnt_dc;
        last_d = gnt_dc ? OWN_DC : gnt_ic ? OWN_IC : last_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= OWN_DC;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between I-cache and D-cache line refills.
// Define AXI_ARB_DCACHE_PRIO_EN to make the D-cache win every tie instead of round-robin.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  err
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int LINE_OFF = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] SAT = CW'(BURST_LEN);
`ifdef AXI_ARB_DCACHE_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d, rlast_q, rlast_d;
    logic                  gnt_ic, gnt_dc, beat, bad_beat;

    // Ready is held low while reset is asserted even if a request is pending.
    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .en         (state_q == IDLE && reset),
        .fixed_prio (FIXED_PRIO),
        .req_ic     (ic_req_valid),
        .req_dc     (dc_req_valid),
        .gnt_ic     (gnt_ic),
        .gnt_dc     (gnt_dc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && (gnt_ic || gnt_dc)) ? ADDR :
                  (state_q == ADDR && m_axi_arready)      ? DATA :
                  (state_q == DATA && beat && m_axi_rlast) ? IDLE : state_q;
    end

    always_comb begin
        m_axi_arvalid = state_q == ADDR;
        m_axi_rready  = state_q == DATA;
        m_axi_araddr  = addr_q & LINE_MASK;
        m_axi_arid    = ID_WIDTH'(owner_q);
        m_axi_arlen   = 8'(BURST_LEN - 1);
        m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
        m_axi_arburst = AXI_BURST_INCR;
        m_axi_arlock  = 1'b0;
        m_axi_arcache = 4'b0011;
        m_axi_arprot  = 3'b000;
        ic_req_ready  = gnt_ic;
        dc_req_ready  = gnt_dc;
        ic_rdata      = rdata_q;
        dc_rdata      = rdata_q;
        ic_rvalid     = ic_rv_q;
        dc_rvalid     = dc_rv_q;
        ic_rlast      = ic_rv_q & rlast_q;
        dc_rlast      = dc_rv_q & rlast_q;
        err           = err_q;
    end

    always_comb begin
        beat     = m_axi_rvalid && state_q == DATA;
        bad_beat = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != ID_WIDTH'(owner_q)) ||
                   (m_axi_rlast ? cnt_q != LAST_IDX : cnt_q >= LAST_IDX);
        owner_d  = gnt_dc ? OWN_DC : gnt_ic ? OWN_IC : owner_q;
        addr_d   = gnt_dc ? dc_req_addr : gnt_ic ? ic_req_addr : addr_q;
        cnt_d    = (state_q == ADDR && m_axi_arready) ? '0 :
                   (beat && cnt_q != SAT) ? cnt_q + CW'(1) : cnt_q;
        err_d    = err_q | (beat & bad_beat);
        rdata_d  = beat ? m_axi_rdata : rdata_q;
        ic_rv_d  = beat && owner_q == OWN_IC;
        dc_rv_d  = beat && owner_q == OWN_DC;
        rlast_d  = beat && m_axi_rlast;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_IC;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ic_rv_q <= 1'b0;
            dc_rv_q <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ic_rv_q <= ic_rv_d;
            dc_rv_q <= dc_rv_d;
            rlast_q <= rlast_d;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed plus randomized refill traffic checked against a transaction-level model.
module tb_axi_read_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req_valid, dc_req_valid, ic_req_ready, dc_req_ready;
    logic [63:0] ic_req_addr, dc_req_addr, ic_rdata, dc_rdata;
    logic        ic_rvalid, ic_rlast, dc_rvalid, dc_rlast;
    logic [12:0] m_axi_arid, m_axi_rid;
    logic [63:0] m_axi_araddr, m_axi_rdata;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst, m_axi_rresp;
    logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_arcache;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready, err;

    int checks = 0;
    int failures = 0;
    bit last_exp = 1'b1;
    bit err_exp = 1'b0;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner of a request set: 0 = IC, 1 = DC.
    function automatic bit pick(input bit i, input bit d);
        if (i && !d) return 1'b0;
        if (d && !i) return 1'b1;
`ifdef AXI_ARB_DCACHE_PRIO_EN
        return 1'b1;
`else
        return last_exp == 1'b0;
`endif
    endfunction

    task automatic all_idle(input string tag);
        check({tag, "_arvalid"}, m_axi_arvalid, 0);
        check({tag, "_rready"}, m_axi_rready, 0);
        check({tag, "_ic_ready"}, ic_req_ready, 0);
        check({tag, "_dc_ready"}, dc_req_ready, 0);
        check({tag, "_rvalids"}, {ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // One refill: entered and left at negedge+1; the next call's grant lands in the cycle after rlast.
    task automatic txn(input bit wi, input bit wd, input logic [63:0] ai, input logic [63:0] ad,
                       input int ar_dly, input int nbeats, input int bad_resp, input int bad_id,
                       input int rst_beat);
        bit w;
        logic [63:0] exp_addr, dat;
        if (wi && !ic_req_valid) begin ic_req_valid = 1'b1; ic_req_addr = ai; end
        if (wd && !dc_req_valid) begin dc_req_valid = 1'b1; dc_req_addr = ad; end
        #1;
        w = pick(ic_req_valid, dc_req_valid);
        exp_addr = (w ? dc_req_addr : ic_req_addr) & ~64'h3f;
        check("grant_ic_ready", ic_req_ready, w == 1'b0);
        check("grant_dc_ready", dc_req_ready, w == 1'b1);
        check("grant_arvalid", m_axi_arvalid, 0);
        last_exp = w;
        @(negedge clk);
        if (w) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
        m_axi_arready = (ar_dly == 0);
        m_axi_rvalid = (ar_dly > 0);
        m_axi_rresp = 2'b11;
        #1;
        check("ar_valid", m_axi_arvalid, 1);
        check("ar_addr", m_axi_araddr, exp_addr);
        check("ar_id", m_axi_arid, 64'(w));
        check("ar_fields", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
              {8'd7, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
        check("ar_rready", m_axi_rready, 0);
        check("ar_wait_readies", {ic_req_ready, dc_req_ready}, 0);
        for (int d = 0; d < ar_dly; d++) begin
            @(negedge clk);
            m_axi_arready = (d == ar_dly - 1);
            m_axi_rvalid = (d != ar_dly - 1);
            #1;
            check("ar_hold_valid", m_axi_arvalid, 1);
            check("ar_hold_addr", m_axi_araddr, exp_addr);
            check("ar_hold_rready", m_axi_rready, 0);
            check("ar_hold_ignored", {ic_rvalid, dc_rvalid, err}, {2'b00, err_exp});
        end
        @(negedge clk);
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rresp = 2'b00;
        #1;
        check("data_arvalid", m_axi_arvalid, 0);
        check("data_rready", m_axi_rready, 1);
        for (int b = 0; b < nbeats; b++) begin
            bit lst;
            lst = (b == nbeats - 1);
            dat = {$urandom, $urandom};
            m_axi_rvalid = 1'b1;
            m_axi_rdata = dat;
            m_axi_rlast = lst;
            m_axi_rresp = (b == bad_resp) ? 2'b10 : 2'b00;
            m_axi_rid = 13'(w) ^ ((b == bad_id) ? 13'h1000 : 13'h0);
            if (b == rst_beat) begin
                #2 reset = 1'b0;
                #1 all_idle("async_rst");
                @(negedge clk);
                reset = 1'b1;
                m_axi_rvalid = 1'b0;
                m_axi_rlast = 1'b0;
                last_exp = 1'b1;
                err_exp = 1'b0;
                return;
            end
            err_exp |= (b == bad_resp) || (b == bad_id) || (lst ? b != 7 : b >= 7);
            @(negedge clk);
            m_axi_rvalid = 1'b0;
            m_axi_rlast = 1'b0;
            m_axi_rresp = 2'b00;
            #1;
            check("beat_owner_rvalid", w ? dc_rvalid : ic_rvalid, 1);
            check("beat_other_rvalid", w ? ic_rvalid : dc_rvalid, 0);
            check("beat_rdata", w ? dc_rdata : ic_rdata, dat);
            check("beat_rlast", {ic_rlast, dc_rlast}, lst ? (w ? 2'b01 : 2'b10) : 2'b00);
            check("beat_err", err, err_exp);
            if (!lst && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                #1;
                check("gap_rvalid", {ic_rvalid, dc_rvalid}, 0);
            end
        end
        check("end_rready", m_axi_rready, 0);
    endtask

    initial begin
        reset = 1'b0;
        {ic_req_valid, dc_req_valid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
        ic_req_addr = '0;
        dc_req_addr = '0;
        m_axi_rid = '0;
        m_axi_rdata = '0;
        m_axi_rresp = '0;
        repeat (2) @(negedge clk);
        #1 all_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        txn(1, 1, 64'h2000_0040, 64'h3000_0080, 0, 8, -1, -1, -1);
        txn(0, 0, 64'h0, 64'h0, 0, 8, -1, -1, -1);
        txn(1, 1, 64'h2000_1000, 64'h3000_2000, 0, 8, -1, -1, -1);
        txn(0, 0, 64'h0, 64'h0, 1, 8, -1, -1, -1);
        txn(1, 0, 64'h1000_0024, 64'h0, 0, 8, -1, -1, -1);
        txn(0, 1, 64'h0, 64'h4444_5555_6666_77ff, 5, 8, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            bit wi, wd;
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            if (!wi && !wd && !ic_req_valid && !dc_req_valid) wi = 1'b1;
            txn(wi, wd, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 8, -1, -1, -1);
        end
        if (ic_req_valid || dc_req_valid) txn(0, 0, 64'h0, 64'h0, 0, 8, -1, -1, -1);
        txn(1, 0, 64'h5000_0000, 64'h0, 0, 8, 3, -1, -1);
        txn(0, 1, 64'h0, 64'h6000_0100, 1, 5, -1, -1, -1);
        txn(1, 0, 64'h7000_0200, 64'h0, 0, 9, -1, 2, -1);
        txn(1, 0, 64'h8000_0300, 64'h0, 0, 8, -1, -1, 4);
        #1;
        txn(1, 0, 64'h9000_0400, 64'h0, 2, 8, -1, -1, -1);
        txn(1, 1, 64'hA000_0500, 64'hB000_0600, 0, 8, -1, -1, -1);
        txn(0, 0, 64'h0, 64'h0, 0, 8, -1, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
